// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM (1-cycle read latency) between the IFU and LSU masters.
// Conflict policy: round-robin when BRAM_ARB_RR_EN is defined, fixed LSU priority otherwise.
module bram_arbiter #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_req_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_resp_data,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_req_addr,
    input  logic                lsu_req_wen,
    input  logic [DATA_W-1:0]   lsu_req_wdata,
    input  logic [DATA_W/8-1:0] lsu_req_wstrb,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_resp_data,

    output logic                mem_en,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                owner_lsu;
    logic                wen_q;
    logic [DATA_W-1:0]   resp_data;
    logic                grant_lsu;
    logic                take_ifu;
    logic                take_lsu;
    logic                resp_done;

`ifdef BRAM_ARB_RR_EN
    logic                last_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_lsu <= 1'b0;
        end else if (take_lsu) begin
            last_lsu <= 1'b1;
        end else if (take_ifu) begin
            last_lsu <= 1'b0;
        end
    end
`endif

    // On a conflict the winner is the master not granted last time (round-robin) or always the LSU.
    always_comb begin
        grant_lsu = lsu_req_valid;
        if (lsu_req_valid && ifu_req_valid) begin
`ifdef BRAM_ARB_RR_EN
            grant_lsu = !last_lsu;
`else
            grant_lsu = 1'b1;
`endif
        end
    end

    assign take_lsu       = (state == IDLE) && lsu_req_valid && grant_lsu;
    assign take_ifu       = (state == IDLE) && ifu_req_valid && !grant_lsu;
    assign ifu_req_ready  = take_ifu;
    assign lsu_req_ready  = take_lsu;
    assign resp_done      = (state == RESP) && (owner_lsu ? lsu_resp_ready : ifu_resp_ready);
    assign ifu_resp_valid = (state == RESP) && !owner_lsu;
    assign lsu_resp_valid = (state == RESP) && owner_lsu;
    assign ifu_resp_data  = resp_data;
    assign lsu_resp_data  = resp_data;
    assign busy           = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take_ifu || take_lsu) state_next = ACCESS;
            ACCESS:  state_next = WAIT;
            WAIT:    state_next = RESP;
            RESP:    if (resp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The mem_* registers double as the latched request: loaded on acceptance, cleared after ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            wen_q     <= 1'b0;
            resp_data <= '0;
            mem_en    <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state     <= state_next;
            mem_en    <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if (take_lsu) begin
                owner_lsu <= 1'b1;
                wen_q     <= lsu_req_wen;
                mem_en    <= 1'b1;
                mem_wen   <= lsu_req_wen;
                mem_addr  <= lsu_req_addr;
                if (lsu_req_wen) begin
                    mem_wdata <= lsu_req_wdata;
                    mem_wstrb <= lsu_req_wstrb;
                end
            end else if (take_ifu) begin
                owner_lsu <= 1'b0;
                wen_q     <= 1'b0;
                mem_en    <= 1'b1;
                mem_addr  <= ifu_req_addr;
            end
            if (state == WAIT) begin
                resp_data <= wen_q ? '0 : mem_rdata;
            end
        end
    end

endmodule
